// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
// Holds the RISC-V funct3 load/store size encodings, the controller state
// enum, the registered request payload and the access-size helper.
package lsu_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        RESP
    } state_t;

    typedef struct packed {
        logic              wr;
        logic [2:0]        ctrl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } lsu_req_t;

    // Number of bytes touched by an access; illegal encodings report 4.
    function automatic logic [2:0] size_bytes(input logic [2:0] ctrl);
        case (ctrl)
            F3_B, F3_BU: size_bytes = 3'd1;
            F3_H, F3_HU: size_bytes = 3'd2;
            default:     size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data.
// Ports: ctrl   - funct3 of the load
//        raw    - little-endian assembled bytes (unused upper bytes are 0)
//        data_c - extended result (combinational)
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]        ctrl,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] data_c
);

    always_comb begin
        data_c = raw;
        case (ctrl)
            F3_B:    data_c = {{24{raw[7]}}, raw[7:0]};
            F3_H:    data_c = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   data_c = {24'h0, raw[7:0]};
            F3_HU:   data_c = {16'h0, raw[15:0]};
            default: data_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu_byte_master.sv
// Load/store initiator driving a byte-wide data memory, one byte per cycle,
// little-endian, with RISC-V load extension.
// Ports: clk/rst_n (sync active-low reset)
//        LSUReq*  - request handshake (Valid/Ready, Wr, Ctrl=funct3, Addr, Data)
//        LSURsp*  - response handshake (Valid/Ready, Data, Err)
//        Mem*     - byte memory port (En, Wr, Addr, WData, RData one cycle later)
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W
// accesses instead of performing them byte-wise.
module lsu_byte_master
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              LSUReqValid,
    output logic              LSUReqReady,
    input  logic              LSUReqWr,
    input  logic [2:0]        LSUReqCtrl,
    input  logic [ADDR_W-1:0] LSUReqAddr,
    input  logic [DATA_W-1:0] LSUReqData,
    output logic              LSURspValid,
    input  logic              LSURspReady,
    output logic [DATA_W-1:0] LSURspData,
    output logic              LSURspErr,
    output logic              MemEn,
    output logic              MemWr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWData,
    input  logic [7:0]        MemRData
);

    state_t            state, state_n;
    lsu_req_t          req, req_n;
    logic [1:0]        idx, idx_n;
    logic [1:0]        last, last_n;
    logic              pend, pend_n;
    logic [1:0]        cap_idx, cap_idx_n;
    logic [DATA_W-1:0] result, result_n;

    logic              req_ready_n, rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0] rsp_data_n;
    logic              mem_en_n, mem_wr_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;

    logic [2:0]        size_in_c;
    logic [ADDR_W:0]   end_addr_c;
    logic              bad_ctrl_c, bad_range_c, misalign_c, reject_c;
    logic [1:0]        nxt_idx_c;
    logic [DATA_W-1:0] assembled_c, ext_c;

    // Request legality, evaluated on the live request inputs in IDLE.
    // The end address uses one extra bit so a high address cannot wrap below the limit.
    assign size_in_c   = size_bytes(LSUReqCtrl);
    assign end_addr_c  = {1'b0, LSUReqAddr} + (ADDR_W+1)'(size_in_c) - (ADDR_W+1)'(1);
    assign bad_ctrl_c  = (LSUReqCtrl == 3'b011) || (LSUReqCtrl == 3'b110) ||
                         (LSUReqCtrl == 3'b111) || (LSUReqCtrl[2] && LSUReqWr);
    assign bad_range_c = end_addr_c >= (ADDR_W+1)'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_c  = (((LSUReqCtrl == F3_H) || (LSUReqCtrl == F3_HU)) && LSUReqAddr[0]) ||
                         ((LSUReqCtrl == F3_W) && (LSUReqAddr[1:0] != 2'b00));
`else
    assign misalign_c  = 1'b0;
`endif

    assign reject_c  = bad_ctrl_c || bad_range_c || misalign_c;
    assign nxt_idx_c = idx + 2'd1;

    // Merge the read byte returning this cycle into the partial result.
    always_comb begin
        assembled_c = result;
        if (pend) begin
            assembled_c[{cap_idx, 3'b000} +: 8] = MemRData;
        end
    end

    lsu_extend u_extend (
        .ctrl   (req.ctrl),
        .raw    (assembled_c),
        .data_c (ext_c)
    );

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_n     = state;
        req_n       = req;
        idx_n       = idx;
        last_n      = last;
        result_n    = assembled_c;
        pend_n      = MemEn && !MemWr;
        cap_idx_n   = idx;
        req_ready_n = LSUReqReady;
        rsp_valid_n = LSURspValid;
        rsp_data_n  = LSURspData;
        rsp_err_n   = LSURspErr;
        mem_en_n    = 1'b0;
        mem_wr_n    = 1'b0;
        mem_addr_n  = MemAddr;
        mem_wdata_n = MemWData;

        case (state)
            IDLE: begin
                if (LSUReqValid && LSUReqReady) begin
                    req_n       = '{wr: LSUReqWr, ctrl: LSUReqCtrl,
                                    addr: LSUReqAddr, data: LSUReqData};
                    req_ready_n = 1'b0;
                    if (reject_c) begin
                        state_n     = RESP;
                        rsp_valid_n = 1'b1;
                        rsp_err_n   = 1'b1;
                        rsp_data_n  = '0;
                    end else begin
                        state_n     = XFER;
                        idx_n       = 2'd0;
                        last_n      = 2'(size_in_c - 3'd1);
                        result_n    = '0;
                        mem_en_n    = 1'b1;
                        mem_wr_n    = LSUReqWr;
                        mem_addr_n  = LSUReqAddr;
                        mem_wdata_n = LSUReqData[7:0];
                    end
                end
            end
            XFER: begin
                if (idx != last) begin
                    idx_n       = nxt_idx_c;
                    mem_en_n    = 1'b1;
                    mem_wr_n    = req.wr;
                    mem_addr_n  = req.addr + ADDR_W'(nxt_idx_c);
                    mem_wdata_n = req.data[{nxt_idx_c, 3'b000} +: 8];
                end else if (req.wr) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = '0;
                end else begin
                    state_n     = DRAIN;
                end
            end
            DRAIN: begin
                state_n     = RESP;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b0;
                rsp_data_n  = ext_c;
            end
            RESP: begin
                if (LSURspReady) begin
                    state_n     = IDLE;
                    req_ready_n = 1'b1;
                    rsp_valid_n = 1'b0;
                    rsp_err_n   = 1'b0;
                    rsp_data_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            req         <= '0;
            idx         <= '0;
            last        <= '0;
            pend        <= 1'b0;
            cap_idx     <= '0;
            result      <= '0;
            LSUReqReady <= 1'b1;
            LSURspValid <= 1'b0;
            LSURspData  <= '0;
            LSURspErr   <= 1'b0;
            MemEn       <= 1'b0;
            MemWr       <= 1'b0;
            MemAddr     <= '0;
            MemWData    <= '0;
        end else begin
            state       <= state_n;
            req         <= req_n;
            idx         <= idx_n;
            last        <= last_n;
            pend        <= pend_n;
            cap_idx     <= cap_idx_n;
            result      <= result_n;
            LSUReqReady <= req_ready_n;
            LSURspValid <= rsp_valid_n;
            LSURspData  <= rsp_data_n;
            LSURspErr   <= rsp_err_n;
            MemEn       <= mem_en_n;
            MemWr       <= mem_wr_n;
            MemAddr     <= mem_addr_n;
            MemWData    <= mem_wdata_n;
        end
    end

endmodule

// File: tb/tb_lsu_byte_master.sv
// Scoreboard bench for lsu_byte_master: a byte memory model answers the
// memory port, directed requests push expected responses/writes into queues,
// and a negedge monitor pops and compares them as the DUT presents them.
module tb_lsu_byte_master;
    import lsu_pkg::*;

    localparam int unsigned MEM_BYTES = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        LSUReqValid, LSUReqReady, LSUReqWr;
    logic [2:0]  LSUReqCtrl;
    logic [31:0] LSUReqAddr, LSUReqData;
    logic        LSURspValid, LSURspReady, LSURspErr;
    logic [31:0] LSURspData;
    logic        MemEn, MemWr;
    logic [31:0] MemAddr;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData = 8'h00;

    typedef struct { logic [31:0] d; logic e; int lat; } rsp_exp_t;
    typedef struct { logic [31:0] a; logic [7:0] b; } wr_exp_t;

    rsp_exp_t rq[$];
    wr_exp_t  wq[$];
    rsp_exp_t cur;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  acc_c = 0;
    int  men_cnt = 0;
    bit  in_rsp = 1'b0;
    logic [7:0] mem [0:63];

    lsu_byte_master #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .LSUReqValid (LSUReqValid),
        .LSUReqReady (LSUReqReady),
        .LSUReqWr    (LSUReqWr),
        .LSUReqCtrl  (LSUReqCtrl),
        .LSUReqAddr  (LSUReqAddr),
        .LSUReqData  (LSUReqData),
        .LSURspValid (LSURspValid),
        .LSURspReady (LSURspReady),
        .LSURspData  (LSURspData),
        .LSURspErr   (LSURspErr),
        .MemEn       (MemEn),
        .MemWr       (MemWr),
        .MemAddr     (MemAddr),
        .MemWData    (MemWData),
        .MemRData    (MemRData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory: writes land at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (MemEn) begin
            if (MemWr) mem[MemAddr[5:0]] <= MemWData;
            else       MemRData <= mem[MemAddr[5:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares writes and responses against the queues.
    always @(negedge clk) begin
        wr_exp_t w;
        if (!rst_n) in_rsp = 1'b0;
        if (MemEn) men_cnt++;
        if (MemEn && MemWr) begin
            if (wq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", MemAddr, MemWData);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", MemAddr, w.a);
                chk("wr_data", 32'(MemWData), 32'(w.b));
            end
        end
        if (LSURspValid) begin
            if (!in_rsp) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_rsp: got data %h err %b, required no response", LSURspData, LSURspErr);
                end else begin
                    cur = rq.pop_front();
                    chk("rsp_latency", 32'(cyc - acc_c), 32'(cur.lat));
                    chk("rsp_data", LSURspData, cur.d);
                    chk("rsp_err", 32'(LSURspErr), 32'(cur.e));
                end
                in_rsp = 1'b1;
            end else begin
                chk("rsp_hold_data", LSURspData, cur.d);
                chk("req_ready_busy", 32'(LSUReqReady), 32'd0);
            end
            if (LSURspReady) in_rsp = 1'b0;
        end
        if (LSUReqValid && LSUReqReady && rst_n) acc_c = cyc;
    end

    task automatic do_req(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_d, input logic exp_e,
                          input int lat, input int n, input int hold);
        int t;
        int base;
        @(posedge clk); #1;
        t = 0;
        while (!LSUReqReady && t < 50) begin @(posedge clk); #1; t++; end
        chk("req_ready_idle", 32'(LSUReqReady), 32'd1);
        rq.push_back('{d: exp_d, e: exp_e, lat: lat});
        if (wr && !exp_e) begin
            for (int i = 0; i < n; i++) wq.push_back('{a: addr + 32'(i), b: data[8*i +: 8]});
        end
        base = men_cnt;
        LSURspReady = (hold == 0);
        LSUReqValid = 1'b1;
        LSUReqWr    = wr;
        LSUReqCtrl  = ctrl;
        LSUReqAddr  = addr;
        LSUReqData  = data;
        @(posedge clk); #1;
        LSUReqValid = 1'b0;
        LSUReqWr    = 1'($urandom);
        LSUReqCtrl  = 3'($urandom);
        LSUReqAddr  = $urandom;
        LSUReqData  = $urandom;
        t = 0;
        while (!LSURspValid && t < 20) begin @(posedge clk); #1; t++; end
        if (!LSURspValid) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: got no response, required one within 20 cycles");
        end
        repeat (hold) begin @(posedge clk); #1; end
        LSURspReady = 1'b1;
        @(posedge clk); #1;
        chk("rsp_drop_valid", 32'(LSURspValid), 32'd0);
        chk("rsp_drop_data", LSURspData, 32'd0);
        chk("mem_access_count", 32'(men_cnt - base), exp_e ? 32'd0 : 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[5]  = 8'h11; mem[6]  = 8'h22; mem[7]  = 8'h33;
        mem[16] = 8'h80;
        mem[32] = 8'h34; mem[33] = 8'h92;
        mem[60] = 8'h01; mem[61] = 8'h02; mem[62] = 8'h03; mem[63] = 8'h04;
        rst_n = 1'b0;
        LSUReqValid = 1'b0; LSUReqWr = 1'b0; LSUReqCtrl = 3'b000;
        LSUReqAddr = '0; LSUReqData = '0; LSURspReady = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 32'(LSUReqReady), 32'd1);
        chk("reset_rsp_valid", 32'(LSURspValid), 32'd0);
        chk("reset_rsp_data", LSURspData, 32'd0);
        chk("reset_rsp_err", 32'(LSURspErr), 32'd0);
        chk("reset_mem_en", 32'(MemEn), 32'd0);
        chk("reset_mem_addr", MemAddr, 32'd0);

        //     wr    ctrl    addr          data          exp_d         err  lat n hold
        do_req(1'b1, F3_W,   32'h08,       32'hA1B2C3D4, 32'h0,        1'b0, 5, 4, 0);
        do_req(1'b0, F3_B,   32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0);
        do_req(1'b0, F3_BU,  32'h10,       32'h0,        32'h00000080, 1'b0, 3, 1, 0);
        do_req(1'b0, F3_H,   32'h20,       32'h0,        32'hFFFF9234, 1'b0, 4, 2, 0);
        do_req(1'b0, F3_HU,  32'h20,       32'h0,        32'h00009234, 1'b0, 4, 2, 0);
        do_req(1'b0, F3_W,   32'h08,       32'h0,        32'hA1B2C3D4, 1'b0, 6, 4, 0);
        do_req(1'b0, F3_W,   32'd60,       32'h0,        32'h04030201, 1'b0, 6, 4, 0);
        do_req(1'b0, F3_W,   32'd62,       32'h0,        32'h0,        1'b1, 1, 4, 0);
        do_req(1'b0, 3'b011, 32'h00,       32'h0,        32'h0,        1'b1, 1, 4, 0);
        do_req(1'b1, 3'b100, 32'h00,       32'h55,       32'h0,        1'b1, 1, 1, 0);
        do_req(1'b0, F3_B,   32'd64,       32'h0,        32'h0,        1'b1, 1, 1, 0);
        do_req(1'b0, F3_W,   32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 1, 4, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req(1'b0, F3_W,   32'h05,       32'h0,        32'h0,        1'b1, 1, 4, 0);
`else
        do_req(1'b0, F3_W,   32'h05,       32'h0,        32'hD4332211, 1'b0, 6, 4, 0);
`endif
        do_req(1'b0, F3_H,   32'h20,       32'h0,        32'hFFFF9234, 1'b0, 4, 2, 3);
        do_req(1'b1, F3_B,   32'd63,       32'h1234565A, 32'h0,        1'b0, 2, 1, 0);
        do_req(1'b0, F3_BU,  32'd63,       32'h0,        32'h0000005A, 1'b0, 3, 1, 0);

        // Reset in the second transfer cycle of a word store: only two bytes go out.
        @(posedge clk); #1;
        chk("rst_test_ready", 32'(LSUReqReady), 32'd1);
        wq.push_back('{a: 32'h30, b: 8'h44});
        wq.push_back('{a: 32'h31, b: 8'h33});
        LSUReqValid = 1'b1; LSUReqWr = 1'b1; LSUReqCtrl = F3_W;
        LSUReqAddr = 32'h30; LSUReqData = 32'h11223344;
        @(posedge clk); #1;
        LSUReqValid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_mem_en", 32'(MemEn), 32'd0);
        chk("rst_rsp_valid", 32'(LSURspValid), 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("rst_no_rsp", 32'(LSURspValid), 32'd0);
        end
        chk("rst_req_ready", 32'(LSUReqReady), 32'd1);
        do_req(1'b0, F3_B,   32'h10,       32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_drained", 32'(rq.size()), 32'd0);
        chk("wr_queue_drained", 32'(wq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_byte_master.md
# lsu_byte_master

Load/store initiator that sits between the core's memory stage and the byte-wide data memory. It accepts one load/store request at a time over a valid/ready handshake and issues one byte access per cycle to the memory port, little-endian. For loads it assembles the returned bytes and applies RISC-V sign or zero extension. It returns a single response carrying the read data or an error flag.

## Interface
- MEM_BYTES, 64, size of the data memory in bytes; an access must lie entirely below it.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- LSUReqValid  in  1  request present.
- LSUReqReady  out  1  high only in IDLE.
- LSUReqWr  in  1  1 = store, 0 = load.
- LSUReqCtrl  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- LSUReqAddr  in  32  byte address.
- LSUReqData  in  32  store data.
- LSURspValid  out  1  response present; held until it is accepted.
- LSURspReady  in  1  response accepted.
- LSURspData  out  32  extended load data; 0 for stores and errors.
- LSURspErr  out  1  request rejected; no memory access performed.
- MemEn  out  1  byte access strobe.
- MemWr  out  1  byte write enable, qualified by MemEn.
- MemAddr  out  32  byte address.
- MemWData  out  8  write byte.
- MemRData  in  8  read byte, valid in the cycle after MemEn with MemWr=0.

## Operation
- Reset value of every output is 0, except LSUReqReady, which is 1 in the first cycle after reset.
- FSM states:
  - IDLE: on accept, go to XFER; on a rejected request, go to RESP with Err=1.
  - XFER: issue N byte accesses, N = 1/2/4 from the size. Byte i goes to address Addr+i.
  - DRAIN: loads only; one cycle to capture the last byte.
  - RESP: hold LSURspValid until LSURspReady, then return to IDLE.
- Store byte i: MemWData = LSUReqData[8i+7:8i].
- Load byte i: written into result[8i+7:8i].
- Extension:
  - B and H replicate bit 7 or bit 15 into the upper bits.
  - BU and HU zero-fill the upper bits.
  - W is passed through unchanged.
- A request is rejected, with no MemEn pulse and no state change other than the move to RESP, when any of these hold:
  - Ctrl is 011, 110 or 111.
  - Ctrl is 100 or 101 with Wr=1.
  - Addr+N-1 ≥ MEM_BYTES. This is computed in 33 bits, so there is no 32-bit wrap.
- Request fields are registered at accept; the inputs may change afterwards.
- LSURspReady is ignored outside RESP.
- Reset during any state returns the FSM to IDLE at that edge. The following cycle shows MemEn=0, no response is emitted, and the partial result is discarded.

## Timing
- Accept happens at edge 0, when LSUReqValid and LSUReqReady are both high.
- MemEn is high for cycles 1..N, with consecutive addresses.
- Store: LSURspValid first high in cycle N+1.
- Load: DRAIN in cycle N+1; LSURspValid first high in cycle N+2.
- Error: LSURspValid in cycle 1.
- Throughput: next accept is no earlier than the cycle after the response handshake, because LSUReqReady is low outside IDLE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - H/HU with Addr[0]≠0 is rejected with Err=1.
  - W with Addr[1:0]≠0 is rejected with Err=1.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned accesses are performed byte-wise like aligned ones.
  - Only the range and Ctrl checks produce errors.

## Structure
- lsu_pkg holds:
  - the funct3 encoding constants;
  - the FSM state enum (IDLE, XFER, DRAIN, RESP);
  - a size-in-bytes function from Ctrl.
- One sub-module, lsu_extend, is natural: combinational sign/zero extension from Ctrl and the raw 32-bit assembled data.

## Test plan
- Store word: SW to Addr 0x08 with Data 0xA1B2C3D4 -> writes 0xD4@8, 0xC3@9, 0xB2@10, 0xA1@11 in cycles 1-4; response in cycle 5 with Err=0.
- Signed and unsigned byte load: memory byte 0x10 = 0x80. LB -> 0xFFFFFF80 in cycle 3; LBU -> 0x00000080.
- Halfword load: bytes 0x20/0x21 = 0x34/0x92. LH -> 0xFFFF9234; LHU -> 0x00009234; response in cycle 4.
- Rejections: LW at Addr 62 with MEM_BYTES=64, Ctrl 011, and SBU-style Ctrl 100 with Wr=1 -> each gives Err=1 in cycle 1, no MemEn, LSURspData=0.
- Misaligned access: LW at Addr 0x05 -> with LSU_MISALIGN_TRAP_EN, Err=1 and no access; without it, bytes 5-8 are read and Err=0.
- Backpressure and reset:
  - Hold LSURspReady=0 for 3 cycles -> RspValid and RspData stay stable, LSUReqReady=0.
  - Assert rst_n=0 in XFER cycle 2 of an SW -> MemEn=0 the next cycle, no response, LSUReqReady=1 after release.
